operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer.sv | 117 +++++++++++
 tb/tb_operand_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Sequences latched A/B vector pairs element by element into an external MAC
// and captures the accumulated scalar product once the MAC pipeline has drained.
module operand_sequencer #(
  parameter int unsigned Nbits   = 4,
  parameter int unsigned Ndata   = 3,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Ndata*Nbits-1:0]   A,
  input  logic [Ndata*Nbits-1:0]   B,
  output logic                     mac_clear,
  output logic [Nbits-1:0]         multiplier,
  output logic [Nbits-1:0]         multiplicand,
  input  logic [2*Nbits-1:0]       acc_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*Nbits-1:0]       result
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // One counter serves both the element index in STREAM and the drain count.
  localparam int unsigned MAXC = (Ndata > MAC_LAT) ? Ndata : MAC_LAT;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LAST_EL = CW'(Ndata - 1);
  localparam logic [CW-1:0] LAST_DR = CW'(MAC_LAT - 1);

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [Ndata*Nbits-1:0] a_q, a_d;
  logic [Ndata*Nbits-1:0] b_q, b_d;
  logic [2*Nbits-1:0]     result_q, result_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (cnt_q == LAST_EL) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DR) begin
          cnt_d    = '0;
          result_d = acc_in;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Operand/clear outputs depend only on flops, never on inputs.
  always_comb begin
    mac_clear    = (state_q == CLEAR);
    multiplier   = '0;
    multiplicand = '0;
    if (state_q == STREAM) begin
      multiplier   = a_q[int'(cnt_q) * Nbits +: Nbits];
      multiplicand = b_q[int'(cnt_q) * Nbits +: Nbits];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: a default instance plus an
// Ndata=1/MAC_LAT=2 instance, each driven by a small behavioural MAC.
module tb_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Default instance (Nbits=4, Ndata=3, MAC_LAT=1)
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] A = '0, B = '0;
  logic        in_ready, out_valid, mac_clear;
  logic [3:0]  multiplier, multiplicand;
  logic [7:0]  acc0, result;

  // Small instance (Nbits=4, Ndata=1, MAC_LAT=2)
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [3:0]  A1 = '0, B1 = '0;
  logic        in_ready1, out_valid1, mac_clear1;
  logic [3:0]  multiplier1, multiplicand1;
  logic [7:0]  p1, acc1, result1;

  always #5 clk = ~clk;

  operand_sequencer #(.Nbits(4), .Ndata(3), .MAC_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mac_clear(mac_clear), .multiplier(multiplier),
    .multiplicand(multiplicand), .acc_in(acc0), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  operand_sequencer #(.Nbits(4), .Ndata(1), .MAC_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A1), .B(B1), .mac_clear(mac_clear1), .multiplier(multiplier1),
    .multiplicand(multiplicand1), .acc_in(acc1), .out_valid(out_valid1),
    .out_ready(out_ready1), .result(result1)
  );

  // MAC models: one-cycle accumulator, and product register + accumulator.
  always @(posedge clk) begin
    if (reset || mac_clear) acc0 <= '0;
    else                    acc0 <= acc0 + 8'(multiplier * multiplicand);
  end

  always @(posedge clk) begin
    if (reset) p1 <= '0;
    else       p1 <= 8'(multiplier1 * multiplicand1);
    if (reset || mac_clear1) acc1 <= '0;
    else                     acc1 <= acc1 + p1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts a pair on dut0 and advances to the DONE cycle (T+6).
  task automatic run_pair(input logic [11:0] a, input logic [11:0] b);
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic finish_pair;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (mac_clear !== 1'b0) begin n_err++; $display("FAIL rst_mac_clear: got %b want 0", mac_clear); end
    n_cmp++; if (multiplier !== 4'h0) begin n_err++; $display("FAIL rst_multiplier: got %h want 0", multiplier); end
    n_cmp++; if (multiplicand !== 4'h0) begin n_err++; $display("FAIL rst_multiplicand: got %h want 0", multiplicand); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL rst_result: got %h want 00", result); end
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready1: got %b want 1", in_ready1); end
  endtask

  task automatic test_basic;
    A = 12'h321;
    B = 12'h654;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mac_clear !== 1'b1) begin n_err++; $display("FAIL basic_clear: got %b want 1", mac_clear); end
    n_cmp++; if (multiplier !== 4'h0) begin n_err++; $display("FAIL basic_clear_op: got %h want 0", multiplier); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (multiplier !== 4'(k + 1)) begin n_err++; $display("FAIL basic_mult[%0d]: got %h want %h", k, multiplier, 4'(k + 1)); end
      n_cmp++; if (multiplicand !== 4'(k + 4)) begin n_err++; $display("FAIL basic_mcand[%0d]: got %h want %h", k, multiplicand, 4'(k + 4)); end
      n_cmp++; if (mac_clear !== 1'b0) begin n_err++; $display("FAIL basic_noclear[%0d]: got %b want 0", k, mac_clear); end
    end
    tick();
    n_cmp++; if (multiplier !== 4'h0) begin n_err++; $display("FAIL basic_drain_op: got %h want 0", multiplier); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'h20) begin n_err++; $display("FAIL basic_result: got %h want 20", result); end
    finish_pair();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_max;
    run_pair(12'hFFF, 12'hFFF);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL max_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'hA3) begin n_err++; $display("FAIL max_result: got %h want a3", result); end
    finish_pair();
  endtask

  task automatic test_stall;
    run_pair(12'h321, 12'h654);
    in_valid = 1'b1;
    A = 12'h222;
    B = 12'h111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (result !== 8'h20) begin n_err++; $display("FAIL stall_result[%0d]: got %h want 20", i, result); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mac_clear !== 1'b1) begin n_err++; $display("FAIL stall_accept: got %b want 1", mac_clear); end
    repeat (5) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_new_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'h06) begin n_err++; $display("FAIL stall_new_result: got %h want 06", result); end
    finish_pair();
  endtask

  task automatic test_back_to_back;
    int last = -100;
    int n_acc = 0;
    int n_clr = 0;
    A = 12'h321;
    B = 12'h654;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 23; cyc++) begin
      if (in_ready) begin
        if (n_acc > 0) begin
          n_cmp++; if (cyc - last != 7) begin n_err++; $display("FAIL b2b_period: got %0d want 7", cyc - last); end
        end
        last = cyc;
        n_acc++;
      end
      if (mac_clear) begin
        n_clr++;
        n_cmp++; if (cyc != last + 1) begin n_err++; $display("FAIL b2b_clear_pos: got %0d want %0d", cyc, last + 1); end
      end
      if (out_valid) begin
        n_cmp++; if (result !== 8'h20) begin n_err++; $display("FAIL b2b_result: got %h want 20", result); end
      end
      tick();
    end
    n_cmp++; if (n_acc != 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", n_acc); end
    n_cmp++; if (n_clr != 4) begin n_err++; $display("FAIL b2b_clears: got %0d want 4", n_clr); end
    in_valid = 1'b0;
    repeat (8) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    A = 12'h321;
    B = 12'h654;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (multiplier !== 4'h2) begin n_err++; $display("FAIL mid_stream1: got %h want 2", multiplier); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (multiplier !== 4'h0) begin n_err++; $display("FAIL mid_mult: got %h want 0", multiplier); end
    n_cmp++; if (multiplicand !== 4'h0) begin n_err++; $display("FAIL mid_mcand: got %h want 0", multiplicand); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL mid_result: got %h want 00", result); end
    run_pair(12'h111, 12'h111);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pair_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'h03) begin n_err++; $display("FAIL mid_pair_result: got %h want 03", result); end
    finish_pair();
  endtask

  task automatic test_ndata1;
    A1 = 4'd7;
    B1 = 4'd9;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n_cmp++; if (mac_clear1 !== 1'b1) begin n_err++; $display("FAIL n1_clear: got %b want 1", mac_clear1); end
    tick();
    n_cmp++; if (multiplier1 !== 4'd7) begin n_err++; $display("FAIL n1_mult: got %h want 7", multiplier1); end
    n_cmp++; if (multiplicand1 !== 4'd9) begin n_err++; $display("FAIL n1_mcand: got %h want 9", multiplicand1); end
    tick();
    n_cmp++; if (multiplier1 !== 4'd0) begin n_err++; $display("FAIL n1_drain_op: got %h want 0", multiplier1); end
    tick();
    n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL n1_early_valid: got %b want 0", out_valid1); end
    tick();
    n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL n1_valid: got %b want 1", out_valid1); end
    n_cmp++; if (result1 !== 8'd63) begin n_err++; $display("FAIL n1_result: got %0d want 63", result1); end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL n1_idle: got %b want 1", in_ready1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_ndata1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
